// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM state encoding and
// register-usage helpers used by the hazard and forwarding logic.
package hazard_stall_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_HOLD1 = 1'b1
    } hazard_state_e;

    // Unrecognised opcodes read nothing, so they can never cause a stall.
    function automatic logic op_reads_rs(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI);
    endfunction

    function automatic logic op_reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic op_is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic op_is_alu_write(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/hazard_classifier.sv
// Combinational hazard classifier: returns how many stall cycles the
// instruction in ID needs given what is in flight in EX and MEM.
module hazard_classifier
    import hazard_stall_unit_pkg::*;
(
    input  logic [5:0] IDop,
    input  logic [4:0] IDrs,
    input  logic [4:0] IDrt,
    input  logic [5:0] EXop,
    input  logic [4:0] EXrt,
    input  logic [4:0] EXrd,
    input  logic [5:0] MEMop,
    input  logic [4:0] MEMrt,
    output logic [1:0] stall_n
);

    logic       id_branch;
    logic       ex_writes;
    logic [4:0] ex_dst;
    logic       ex_hit;
    logic       mem_hit;
    logic       ex_is_lw;
    logic       ex_is_alu;

    always_comb begin
        id_branch = op_is_branch(IDop);
        ex_is_lw  = (EXop == OP_LW);
        ex_is_alu = op_is_alu_write(EXop);

        ex_writes = 1'b0;
        ex_dst    = 5'd0;
        if (EXop == OP_RTYPE) begin
            ex_writes = 1'b1;
            ex_dst    = EXrd;
        end else if ((EXop == OP_ADDI) || (EXop == OP_LW)) begin
            ex_writes = 1'b1;
            ex_dst    = EXrt;
        end

        // Register 0 is hardwired, so a match on it is never a real dependency.
        ex_hit = ex_writes && (ex_dst != 5'd0) &&
                 ((op_reads_rs(IDop) && (IDrs == ex_dst)) ||
                  (op_reads_rt(IDop) && (IDrt == ex_dst)));

        mem_hit = (MEMop == OP_LW) && (MEMrt != 5'd0) &&
                  ((op_reads_rs(IDop) && (IDrs == MEMrt)) ||
                   (op_reads_rt(IDop) && (IDrt == MEMrt)));

        stall_n = 2'd0;
        if (id_branch) begin
            if (ex_hit && ex_is_lw) begin
                stall_n = 2'd2;
            end else if ((ex_hit && ex_is_alu) || mem_hit) begin
                stall_n = 2'd1;
            end
        end else if (ex_hit && ex_is_lw) begin
            stall_n = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard stall unit: holds PC and IF/ID, bubbles ID/EX for data
// hazards, flushes IF/ID on taken control transfers, and counts stall cycles.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  IDop,
    input  logic [4:0]  IDrs,
    input  logic [4:0]  IDrt,
    input  logic [5:0]  EXop,
    input  logic [4:0]  EXrt,
    input  logic [4:0]  EXrd,
    input  logic [5:0]  MEMop,
    input  logic [4:0]  MEMrt,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXbubble,
    output logic        IFIDflush,
    output logic [15:0] stall_count
);

    logic [1:0]    stall_n;
    hazard_state_e state_q;
    hazard_state_e state_d;
    logic [15:0]   stall_count_q;
    logic [15:0]   stall_count_d;
    logic          stall;
    logic          flush;

    hazard_classifier u_classifier (
        .IDop    (IDop),
        .IDrs    (IDrs),
        .IDrt    (IDrt),
        .EXop    (EXop),
        .EXrt    (EXrt),
        .EXrd    (EXrd),
        .MEMop   (MEMop),
        .MEMrt   (MEMrt),
        .stall_n (stall_n)
    );

    always_comb begin
        stall         = 1'b0;
        flush         = 1'b0;
        state_d       = state_q;
        stall_count_d = stall_count_q;

        // While reset is held the pipeline free-runs with no stall or flush.
        if (!reset) begin
            stall = (state_q == ST_HOLD1) || (stall_n != 2'd0);
            flush = !stall &&
                    ((IDop == OP_J) || (op_is_branch(IDop) && branch_taken));
        end

        case (state_q)
            ST_RUN:   state_d = (stall_n == 2'd2) ? ST_HOLD1 : ST_RUN;
            ST_HOLD1: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (stall && (stall_count_q != STALL_COUNT_MAX)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign PCWrite     = !stall;
    assign IFIDWrite   = !stall;
    assign IDEXbubble  = stall;
    assign IFIDflush   = flush;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios plus random traffic
// checked against a pending-stall reference model.
module tb_hazard_stall_unit;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam int W = 20;

    typedef struct packed {
        logic       rst;
        logic [5:0] idop;
        logic [4:0] idrs;
        logic [4:0] idrt;
        logic [5:0] exop;
        logic [4:0] exrt;
        logic [4:0] exrd;
        logic [5:0] memop;
        logic [4:0] memrt;
        logic       taken;
    } stim_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  IDop = '0;
    logic [4:0]  IDrs = '0;
    logic [4:0]  IDrt = '0;
    logic [5:0]  EXop = '0;
    logic [4:0]  EXrt = '0;
    logic [4:0]  EXrd = '0;
    logic [5:0]  MEMop = '0;
    logic [4:0]  MEMrt = '0;
    logic        branch_taken = 1'b0;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEXbubble;
    logic        IFIDflush;
    logic [15:0] stall_count;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int m_pend = 0;
    int m_count = 0;
    bit m_prev_bub = 1'b0;

    hazard_stall_unit dut (
        .clk          (clk),
        .reset        (reset),
        .IDop         (IDop),
        .IDrs         (IDrs),
        .IDrt         (IDrt),
        .EXop         (EXop),
        .EXrt         (EXrt),
        .EXrd         (EXrd),
        .MEMop        (MEMop),
        .MEMrt        (MEMrt),
        .branch_taken (branch_taken),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IDEXbubble   (IDEXbubble),
        .IFIDflush    (IFIDflush),
        .stall_count  (stall_count)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // Reference model: register usage straight from the ISA rules.
    function automatic bit uses_rs(input logic [5:0] op);
        return op inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI};
    endfunction

    function automatic bit uses_rt(input logic [5:0] op);
        return op inside {T_RTYPE, T_SW, T_BEQ, T_BNE};
    endfunction

    function automatic bit id_needs(input stim_t s, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (uses_rs(s.idop) && s.idrs == r) || (uses_rt(s.idop) && s.idrt == r);
    endfunction

    function automatic int needed_stalls(input stim_t s);
        logic [4:0] ex_dst;
        bit branch, ex_hit, mem_hit;
        int n;
        ex_dst = 5'd0;
        if (s.exop == T_RTYPE) ex_dst = s.exrd;
        else if (s.exop == T_ADDI || s.exop == T_LW) ex_dst = s.exrt;
        branch  = (s.idop == T_BEQ) || (s.idop == T_BNE);
        ex_hit  = id_needs(s, ex_dst);
        mem_hit = (s.memop == T_LW) && id_needs(s, s.memrt);
        n = 0;
        if (branch && ex_hit && s.exop == T_LW) n = 2;
        if (branch && ex_hit && (s.exop == T_RTYPE || s.exop == T_ADDI) && n < 1) n = 1;
        if (branch && mem_hit && n < 1) n = 1;
        if (!branch && ex_hit && s.exop == T_LW && n < 1) n = 1;
        return n;
    endfunction

    function automatic stim_t mk(input logic rst, input logic [5:0] idop,
                                 input logic [4:0] idrs, input logic [4:0] idrt,
                                 input logic [5:0] exop, input logic [4:0] exrt,
                                 input logic [4:0] exrd, input logic [5:0] memop,
                                 input logic [4:0] memrt, input logic taken);
        stim_t s;
        s.rst = rst; s.idop = idop; s.idrs = idrs; s.idrt = idrt;
        s.exop = exop; s.exrt = exrt; s.exrd = exrd;
        s.memop = memop; s.memrt = memrt; s.taken = taken;
        return s;
    endfunction

    // Driver: one call per clock cycle, pushes the expected outputs for it.
    task automatic apply(input stim_t s);
        bit stall, flush;
        int n;
        logic [15:0] cnt16;
        @(posedge clk);
        #1;
        cyc++;
        if (m_prev_bub && m_count < 65535) m_count++;
        reset = s.rst; IDop = s.idop; IDrs = s.idrs; IDrt = s.idrt;
        EXop = s.exop; EXrt = s.exrt; EXrd = s.exrd;
        MEMop = s.memop; MEMrt = s.memrt; branch_taken = s.taken;
        stall = 1'b0;
        flush = 1'b0;
        if (s.rst) begin
            m_count = 0;
            m_pend = 0;
        end else begin
            if (m_pend > 0) begin
                stall = 1'b1;
                m_pend--;
            end else begin
                n = needed_stalls(s);
                stall = (n > 0);
                m_pend = (n > 0) ? n - 1 : 0;
            end
            flush = !stall && (s.idop == T_J ||
                               ((s.idop == T_BEQ || s.idop == T_BNE) && s.taken));
        end
        m_prev_bub = stall;
        cnt16 = m_count[15:0];
        exp_q.push_back({!stall, !stall, stall, flush, cnt16});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {PCWrite, IFIDWrite, IDEXbubble, IFIDflush, stall_count};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: got pcw=%b ifidw=%b bub=%b flush=%b cnt=%h, expected pcw=%b ifidw=%b bub=%b flush=%b cnt=%h",
                         cyc, act_v[19], act_v[18], act_v[17], act_v[16], act_v[15:0],
                         exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
            end
        end
    end

    stim_t idle;
    logic [5:0] op_tab[8];

    initial begin
        idle = mk(1'b0, T_ADDI, 5'd1, 5'd0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0);
        op_tab = '{T_RTYPE, T_J, T_BEQ, T_BNE, T_ADDI, T_LW, T_SW, 6'b111111};

        // Reset state
        repeat (3) apply(mk(1'b1, T_BEQ, 5'd7, 5'd0, T_LW, 5'd7, 5'd0, 6'd0, 5'd0, 1'b1));
        apply(idle);

        // Load-use: one stall then release, counter reaches 1
        apply(mk(1'b0, T_RTYPE, 5'd1, 5'd5, T_LW, 5'd5, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b0, T_RTYPE, 5'd1, 5'd5, 6'd0, 5'd5, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(idle);

        // Branch after LW: two stalls even though EX clears after the first
        apply(mk(1'b0, T_BEQ, 5'd7, 5'd0, T_LW, 5'd7, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b0, T_BEQ, 5'd7, 5'd0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b0, T_BEQ, 5'd7, 5'd0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(idle);

        // Branch after ALU, and no hazard on register 0
        apply(mk(1'b0, T_BNE, 5'd1, 5'd3, T_ADDI, 5'd3, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b0, T_BNE, 5'd1, 5'd3, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b0, T_BEQ, 5'd0, 5'd0, T_LW, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));

        // Flush on J, suppressed while a taken branch is stalled
        apply(mk(1'b0, T_J, 5'd9, 5'd9, T_LW, 5'd9, 5'd9, T_LW, 5'd9, 1'b0));
        apply(mk(1'b0, T_BEQ, 5'd4, 5'd2, 6'd0, 5'd0, 5'd0, T_LW, 5'd4, 1'b1));
        apply(mk(1'b0, T_BEQ, 5'd4, 5'd2, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b1));
        apply(idle);

        // Reset in HOLD1 abandons the second stall cycle
        apply(mk(1'b0, T_BEQ, 5'd7, 5'd0, T_LW, 5'd7, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b1, T_BEQ, 5'd7, 5'd0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(mk(1'b0, T_BEQ, 5'd7, 5'd0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));
        apply(idle);

        // Random traffic over a small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            s.rst   = ($urandom_range(0, 79) == 0);
            s.idop  = op_tab[$urandom_range(0, 7)];
            s.idrs  = 5'($urandom_range(0, 3));
            s.idrt  = 5'($urandom_range(0, 3));
            s.exop  = op_tab[$urandom_range(0, 7)];
            s.exrt  = 5'($urandom_range(0, 3));
            s.exrd  = 5'($urandom_range(0, 3));
            s.memop = op_tab[$urandom_range(0, 7)];
            s.memrt = 5'($urandom_range(0, 3));
            s.taken = 1'($urandom_range(0, 1));
            apply(s);
        end

        // Saturation: continuous load-use from a clean counter
        apply(mk(1'b1, T_ADDI, 5'd1, 5'd0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 1'b0));
        for (int i = 0; i < 65540; i++) begin
            apply(mk(1'b0, T_RTYPE, 5'd1, 5'd5, T_LW, 5'd5, 5'd0, 6'd0, 5'd0, 1'b0));
        end
        apply(idle);
        apply(idle);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset; ports are named clk and reset.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- IDop  in  6  opcode of instruction in ID
- IDrs, IDrt  in  5 each  ID source registers
- EXop  in  6  opcode in EX
- EXrt, EXrd  in  5 each  EX register fields
- MEMop  in  6  opcode in MEM
- MEMrt  in  5  MEM rt field
- branch_taken  in  1  ID-stage branch comparator result
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IDEXbubble  out  1  zero ID/EX control (insert NOP)
- IFIDflush  out  1  squash IF/ID contents
- stall_count  out  16  stall-cycle performance counter

Function
REQ-003 SHALL recognise opcodes LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010; any other opcode reads and writes no registers.
REQ-004 SHALL treat ID as reading rs for every opcode except J, and rt only for RTYPE, SW, BEQ, BNE.
REQ-005 SHALL treat the EX destination as EXrd for RTYPE, EXrt for ADDI/LW, none otherwise; the MEM destination as MEMrt only when MEMop is LW.
REQ-006 SHALL never flag a hazard on register 0.
REQ-007 SHALL compute the required stall count N combinationally:
- N=2: ID is BEQ/BNE and EX is LW writing a register ID reads.
- N=1: ID is BEQ/BNE and EX is RTYPE/ADDI writing a register ID reads.
- N=1: ID is BEQ/BNE and MEM is LW writing a register ID reads.
- N=1: ID is a non-branch and EX is LW writing a register ID reads.
- N=0: all other cases; the largest applicable N wins.
REQ-008 SHALL implement the FSM states RUN and HOLD1.
REQ-009 In RUN with N>=1, the unit SHALL assert stall this cycle (PCWrite=0, IFIDWrite=0, IDEXbubble=1); the next state SHALL be HOLD1 if N=2, else RUN.
REQ-010 In HOLD1, the unit SHALL assert stall unconditionally without re-evaluating N, then return to RUN.
REQ-011 With no stall, outputs SHALL be PCWrite=1, IFIDWrite=1, IDEXbubble=0.
REQ-012 IFIDflush SHALL be 1 only when not stalling and (IDop=J, or IDop is BEQ/BNE with branch_taken=1).
REQ-013 Stall SHALL take precedence over flush: no flush while a branch is stalled.
REQ-014 All outputs except stall_count SHALL be combinational from state and inputs, with zero latency.
REQ-015 stall_count SHALL increment by 1 on each rising edge where IDEXbubble=1, and SHALL saturate at 0xFFFF with no wrap.

Reset
REQ-016 Reset SHALL force state RUN and stall_count=0 immediately, regardless of clock.
REQ-017 While reset=1, outputs SHALL be PCWrite=1, IFIDWrite=1, IDEXbubble=0, IFIDflush=0.
REQ-018 Reset asserted in HOLD1 SHALL abandon the pending stall; after release, the unit SHALL evaluate fresh in RUN.

Structure
REQ-019 Opcode constants and the state encoding SHALL reside in a shared pipeline package, reused by the forwarding units.
REQ-020 The N computation SHALL be one combinational sub-module, hazard_classifier; the FSM and counter SHALL be in the top module.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Load-use: EXop=LW, EXrt=5, IDop=RTYPE, IDrt=5 -> one cycle with PCWrite=0, IDEXbubble=1; next cycle (EXop=0) PCWrite=1; stall_count=1.
- Branch after LW: EXop=LW, EXrt=7, IDop=BEQ, IDrs=7 -> exactly 2 consecutive stall cycles even if EX inputs clear after the first; stall_count=2.
- Branch after ALU: EXop=ADDI, EXrt=3, IDop=BNE, IDrt=3 -> 1 stall; EXop=LW, EXrt=0, IDop=BEQ, IDrs=0 -> no stall.
- Flush and precedence: IDop=J -> IFIDflush=1, PCWrite=1; IDop=BEQ, branch_taken=1 with MEMop=LW, MEMrt=IDrs=4 -> IFIDflush=0 during the stall cycle.
- Reset in HOLD1: assert reset mid-way through the 2-cycle branch stall -> outputs return to no-stall at once, stall_count=0, no second stall after release.
- Saturation: hold load-use for 65540 cycles -> stall_count stays at 0xFFFF.
